// File: rtl/button_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : button_ctrl_pkg
// Brief   : Shared register addresses and debounce count type for the
//           button debounce controller.
// Revision: 1.0
// ============================================================================
package button_ctrl_pkg;

    localparam int CNT_W_DEFAULT = 20;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_DBNC = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef logic [CNT_W_DEFAULT-1:0] dbnc_cnt_t;

endpackage
`default_nettype wire

// File: rtl/button_debounce_ctrl_cell.sv
`default_nettype none
// ============================================================================
// Module  : debounce_cell
// Brief   : One key: 2-flop synchroniser, saturating debounce counter,
//           stable level and one-cycle rise/fall pulses.
// Revision: 1.0
// ============================================================================
module debounce_cell
    import button_ctrl_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEFAULT,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_raw,
    input  logic [CNT_W-1:0] i_thresh,
    output logic             o_stable,
    output logic             o_rise,
    output logic             o_fall
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_q;
    logic [CNT_W-1:0] r_cnt;

    logic             w_pressed;
    logic [CNT_W:0]   w_cnt_inc;
    logic [CNT_W:0]   w_thresh_eff;
    logic             w_expire;

    // Polarity is folded in ahead of the synchroniser so reset means "not pressed".
    assign w_pressed    = (ACTIVE_LOW != 0) ? ~i_raw : i_raw;
    assign w_cnt_inc    = {1'b0, r_cnt} + (CNT_W+1)'(1);
    assign w_thresh_eff = (i_thresh == '0) ? (CNT_W+1)'(1) : {1'b0, i_thresh};
    assign w_expire     = (w_cnt_inc >= w_thresh_eff);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_q <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= w_pressed;
            r_sync2    <= r_sync1;
            r_stable_q <= r_stable;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (w_expire) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else if (!(&r_cnt)) begin
                r_cnt <= w_cnt_inc[CNT_W-1:0];
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_stable & ~r_stable_q;
    assign o_fall   = ~r_stable & r_stable_q;

endmodule
`default_nettype wire

// File: rtl/button_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : button_debounce_ctrl
// Brief   : Avalon-MM push-button controller: debounced DATA, DBNC threshold,
//           irq MASK and W1C EDGE capture. Define BUTTON_RELEASE_CAPTURE_EN to
//           also capture releases in EDGE[2*WIDTH-1:WIDTH].
// Revision: 1.0
// ============================================================================
module button_debounce_ctrl
    import button_ctrl_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int CNT_W        = CNT_W_DEFAULT,
    parameter int DBNC_DEFAULT = 500000,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

`ifdef BUTTON_RELEASE_CAPTURE_EN
    localparam int EDGE_W = 2 * WIDTH;
`else
    localparam int EDGE_W = WIDTH;
`endif

    logic [WIDTH-1:0]  w_stable;
    logic [WIDTH-1:0]  w_rise;
    logic [WIDTH-1:0]  w_fall;
    logic [EDGE_W-1:0] w_edge_set;
    logic [EDGE_W-1:0] w_edge_clr;
    logic              w_wr_dbnc;
    logic              w_wr_mask;
    logic              w_wr_edge;
    logic [31:0]       w_rdata;
    logic              w_unused;

    logic [CNT_W-1:0]  r_dbnc;
    logic [EDGE_W-1:0] r_mask;
    logic [EDGE_W-1:0] r_edge;
    logic [31:0]       r_readdata;
    logic              r_irq;

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        debounce_cell #(
            .CNT_W      (CNT_W),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_cell (
            .clk      (clk),
            .rst      (reset),
            .i_raw    (in_port[g]),
            .i_thresh (r_dbnc),
            .o_stable (w_stable[g]),
            .o_rise   (w_rise[g]),
            .o_fall   (w_fall[g])
        );
    end

`ifdef BUTTON_RELEASE_CAPTURE_EN
    assign w_edge_set = {w_fall, w_rise};
    assign w_unused   = ^writedata;
`else
    assign w_edge_set = w_rise;
    assign w_unused   = ^{writedata, w_fall};
`endif

    assign w_wr_dbnc  = chipselect && write && (address == ADDR_DBNC);
    assign w_wr_mask  = chipselect && write && (address == ADDR_MASK);
    assign w_wr_edge  = chipselect && write && (address == ADDR_EDGE);
    assign w_edge_clr = w_wr_edge ? writedata[EDGE_W-1:0] : '0;

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA: w_rdata[WIDTH-1:0]  = w_stable;
            ADDR_DBNC: w_rdata[CNT_W-1:0]  = r_dbnc;
            ADDR_MASK: w_rdata[EDGE_W-1:0] = r_mask;
            ADDR_EDGE: w_rdata[EDGE_W-1:0] = r_edge;
            default:   w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dbnc     <= CNT_W'(DBNC_DEFAULT);
            r_mask     <= '0;
            r_edge     <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_dbnc) r_dbnc <= writedata[CNT_W-1:0];
            if (w_wr_mask) r_mask <= writedata[EDGE_W-1:0];
            // New events are OR-ed in after the clear so a same-cycle capture survives.
            r_edge     <= (r_edge & ~w_edge_clr) | w_edge_set;
            r_readdata <= w_rdata;
            r_irq      <= |(r_edge & r_mask);
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_button_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_debounce_ctrl
// Brief   : Self-checking bench for button_debounce_ctrl: directed vectors plus
//           randomized traffic compared against a cycle-level reference model.
// Revision: 1.0
// ============================================================================
module tb_button_debounce_ctrl;
    import button_ctrl_pkg::*;

    localparam int W        = 4;
    localparam int CW       = CNT_W_DEFAULT;
    localparam int DBNC_DEF = 40;
`ifdef BUTTON_RELEASE_CAPTURE_EN
    localparam int EW = 2 * W;
`else
    localparam int EW = W;
`endif

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic [1:0]    address    = 2'd0;
    logic          chipselect = 1'b0;
    logic          write      = 1'b0;
    logic [31:0]   writedata  = 32'd0;
    logic [31:0]   readdata;
    logic [W-1:0]  in_port    = '1;
    logic          irq;

    button_debounce_ctrl #(
        .WIDTH        (W),
        .CNT_W        (CW),
        .DBNC_DEFAULT (DBNC_DEF),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: synchronised samples, debounced level, disagreement run length.
    logic [W-1:0]  m_s1, m_s2, m_st, m_st_d;
    int unsigned   m_run [W];
    dbnc_cnt_t     m_dbnc;
    logic [EW-1:0] m_mask, m_edge;
    logic [31:0]   m_rd;
    logic          m_irq;

    typedef struct {
        string      name;
        logic [1:0] addr;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t rst_tbl [4];
    rd_vec_t mid_tbl [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_step();
        logic [W-1:0]  pressed, st_n, rise, fall;
        logic [EW-1:0] setv, clr;
        logic [31:0]   rd;
        int unsigned   thr;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_st = '0; m_st_d = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
            m_dbnc = dbnc_cnt_t'(DBNC_DEF);
            m_mask = '0; m_edge = '0; m_rd = '0; m_irq = 1'b0;
            return;
        end
        pressed = ~in_port;
        rd = '0;
        case (address)
            2'd0:    rd[W-1:0]  = m_st;
            2'd1:    rd[CW-1:0] = m_dbnc;
            2'd2:    rd[EW-1:0] = m_mask;
            default: rd[EW-1:0] = m_edge;
        endcase
        m_rd  = rd;
        m_irq = |(m_edge & m_mask);
        rise = m_st & ~m_st_d;
        fall = ~m_st & m_st_d;
`ifdef BUTTON_RELEASE_CAPTURE_EN
        setv = {fall, rise};
`else
        setv = rise;
        if (fall != fall) setv = '0;
`endif
        clr    = (chipselect && write && address == 2'd3) ? writedata[EW-1:0] : '0;
        m_edge = (m_edge & ~clr) | setv;
        // A key adopts the synchronised level after max(DBNC,1) consecutive disagreeing samples.
        thr  = (m_dbnc == 0) ? 1 : int'(m_dbnc);
        st_n = m_st;
        for (int i = 0; i < W; i++) begin
            if (m_s2[i] == m_st[i]) m_run[i] = 0;
            else if (m_run[i] + 1 >= thr) begin
                st_n[i]  = m_s2[i];
                m_run[i] = 0;
            end else m_run[i] = m_run[i] + 1;
        end
        m_st_d = m_st;
        m_st   = st_n;
        m_s2   = m_s1;
        m_s1   = pressed;
        if (chipselect && write && address == 2'd1) m_dbnc = writedata[CW-1:0];
        if (chipselect && write && address == 2'd2) m_mask = writedata[EW-1:0];
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("model readdata", readdata, m_rd);
        check("model irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        tick();
        check(name, readdata, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_tbl[0] = '{"reset DATA", 2'd0, 32'h0};
        rst_tbl[1] = '{"reset DBNC", 2'd1, 32'(DBNC_DEF)};
        rst_tbl[2] = '{"reset MASK", 2'd2, 32'h0};
        rst_tbl[3] = '{"reset EDGE", 2'd3, 32'h0};
        mid_tbl[0] = '{"midreset EDGE", 2'd3, 32'h0};
        mid_tbl[1] = '{"midreset DATA", 2'd0, 32'h0};
        mid_tbl[2] = '{"midreset DBNC", 2'd1, 32'(DBNC_DEF)};

        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) rd_chk(rst_tbl[i].name, rst_tbl[i].addr, rst_tbl[i].exp);
        check("reset irq", {31'd0, irq}, 32'd0);

        // Clean press of key0 with DBNC=4
        wr(2'd1, 32'd4);
        address = 2'd0;
        in_port = 4'b1110;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("clean press DATA timing", readdata, (i == 7) ? 32'h1 : 32'h0);
        end
        rd_chk("clean press EDGE", 2'd3, 32'h1);
        check("clean press irq masked", {31'd0, irq}, 32'd0);
        in_port = 4'hF;
        ticks(10);
        wr(2'd3, 32'hFF);

        // Bounce on key1 shorter than DBNC=8
        wr(2'd1, 32'd8);
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) in_port[1] = ~in_port[1];
            tick();
        end
        in_port = 4'hF;
        ticks(12);
        rd_chk("bounce DATA", 2'd0, 32'h0);
        rd_chk("bounce EDGE", 2'd3, 32'h0);

        // IRQ and W1C on key2
        wr(2'd2, 32'hF);
        in_port = 4'b1011;
        ticks(14);
        rd_chk("irq EDGE set", 2'd3, 32'h4);
        check("irq asserted", {31'd0, irq}, 32'd1);
        wr(2'd3, 32'h4);
        rd_chk("W1C EDGE cleared", 2'd3, 32'h0);
        check("W1C irq cleared", {31'd0, irq}, 32'd0);
        in_port = 4'hF;
        ticks(14);
        wr(2'd3, 32'hFF);
        in_port = 4'b1011;
        ticks(10);
        wr(2'd3, 32'h4);
        rd_chk("set wins over W1C", 2'd3, 32'h4);
        in_port = 4'hF;
        ticks(14);
        wr(2'd3, 32'hFF);

        // Threshold lowered mid-count on key3
        wr(2'd1, 32'd100);
        in_port = 4'b0111;
        ticks(50);
        wr(2'd1, 32'd10);
        address = 2'd0;
        ticks(2);
        check("threshold change DATA", readdata, 32'h8);

        // Reset while key0 is held
        in_port = 4'hF;
        ticks(20);
        wr(2'd3, 32'hFF);
        in_port = 4'b1110;
        ticks(20);
        rd_chk("pre-reset EDGE", 2'd3, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) rd_chk(mid_tbl[i].name, mid_tbl[i].addr, mid_tbl[i].exp);
        address = 2'd3;
        n = 0;
        do begin
            tick();
            n++;
        end while (readdata == 32'h0 && n < 200);
        check("recapture latency", 32'(3 + n), 32'(DBNC_DEF + 4));
        in_port = 4'hF;
        ticks(DBNC_DEF + 5);
`ifdef BUTTON_RELEASE_CAPTURE_EN
        rd_chk("release capture EDGE", 2'd3, 32'h11);
`else
        rd_chk("release not captured EDGE", 2'd3, 32'h1);
`endif

        // Randomized traffic against the reference model
        wr(2'd1, 32'd5);
        for (int k = 0; k < 3000; k++) begin
            int b;
            if ($urandom_range(0, 7) == 0) begin
                b = int'($urandom_range(0, W - 1));
                in_port[b] = ~in_port[b];
            end
            chipselect = ($urandom_range(0, 5) == 0);
            write      = ($urandom_range(0, 1) == 0);
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            if (address == 2'd1) writedata = (writedata & 32'hFFF0_0000) | 32'($urandom_range(0, 12));
            reset      = ($urandom_range(0, 599) == 0);
            tick();
        end
        reset = 1'b0; chipselect = 1'b0; write = 1'b0;
        ticks(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
